// File: rtl/gate_truth_checker_if.sv
// Stimulus/response bundle between a gate truth-table checker and whoever launches it.
// The master side launches sweeps and supplies the gate output; the slave side is the checker.
interface gate_truth_checker_if #(
    parameter int unsigned N_IN = 2
) ();
    logic                   start;
    logic                   abort;
    logic [N_IN-1:0]        stim;
    logic                   resp;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(1<<N_IN)-1:0]   fail_vec;
    logic [N_IN:0]          err_count;

    modport master (
        output start, abort, resp,
        input  stim, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        input  start, abort, resp,
        output stim, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Sweeps every input combination of an N_IN-input gate, holds each for SETTLE+1 cycles,
// and records which vectors produced a response differing from the EXPECTED truth table.
module gate_truth_checker #(
    parameter int unsigned          N_IN     = 2,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 4'b1000,
    parameter int unsigned          SETTLE   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    gate_truth_checker_if.slave bus
);
    localparam int unsigned     NV          = 1 << N_IN;
    localparam int unsigned     SW          = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC    = '1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t          state, state_d;
    logic [N_IN-1:0] stim, stim_d;
    logic [SW-1:0]   settle, settle_d;
    logic            busy, busy_d;
    logic            done, done_d;
    logic            pass, pass_d;
    logic [NV-1:0]   fail_vec, fail_d;
    logic [N_IN:0]   err_count, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stim      <= '0;
            settle    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= '0;
            err_count <= '0;
        end else begin
            state     <= state_d;
            stim      <= stim_d;
            settle    <= settle_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
            fail_vec  <= fail_d;
            err_count <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        stim_d   = stim;
        settle_d = settle;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        fail_d   = fail_vec;
        err_d    = err_count;

        if (bus.abort) begin
            state_d  = IDLE;
            stim_d   = '0;
            settle_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            pass_d   = 1'b0;
            fail_d   = '0;
            err_d    = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == IDLE) begin
                        stim_d = '0;
                    end
                    // Relaunch from DONE clears the previous results on the same edge.
                    if (bus.start) begin
                        state_d  = DRIVE;
                        stim_d   = '0;
                        settle_d = '0;
                        busy_d   = 1'b1;
                        done_d   = 1'b0;
                        pass_d   = 1'b0;
                        fail_d   = '0;
                        err_d    = '0;
                    end
                end

                DRIVE: begin
                    busy_d = 1'b1;
                    if (settle != SETTLE_LAST) begin
                        settle_d = settle + SW'(1);
                    end else begin
                        if (bus.resp !== EXPECTED[stim]) begin
                            fail_d[stim] = 1'b1;
                            err_d        = err_count + (N_IN + 1)'(1);
                        end
                        if (stim == LAST_VEC) begin
                            // pass must reflect the final vector sampled on this same edge.
                            state_d  = DONE;
                            stim_d   = '0;
                            settle_d = '0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            pass_d   = (fail_d == '0);
                        end else begin
                            stim_d   = stim + N_IN'(1);
                            settle_d = '0;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.stim      = stim;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.pass      = pass;
    assign bus.fail_vec  = fail_vec;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (AND table with SETTLE=2, OR table with SETTLE=0)
// driven by gate truth tables, with results predicted from the truth-table comparison directly.
module tb_gate_truth_checker;
    localparam int unsigned N_IN  = 2;
    localparam int          NV    = 4;
    localparam logic [3:0]  EXP_A = 4'b1000;
    localparam logic [3:0]  EXP_B = 4'b1110;
    localparam int          SET_A = 2;
    localparam int          SET_B = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_truth_checker_if #(.N_IN(N_IN)) bus_a ();
    gate_truth_checker_if #(.N_IN(N_IN)) bus_b ();

    gate_truth_checker #(.N_IN(N_IN), .EXPECTED(EXP_A), .SETTLE(SET_A)) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a.slave)
    );

    gate_truth_checker #(.N_IN(N_IN), .EXPECTED(EXP_B), .SETTLE(SET_B)) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b.slave)
    );

    // The "gate under test" is just a truth table looked up by the current stimulus.
    logic [3:0] tab_a = 4'b0000;
    logic [3:0] tab_b = 4'b0000;
    assign bus_a.resp = tab_a[bus_a.stim];
    assign bus_b.resp = tab_b[bus_b.stim];

    logic       sel = 1'b0;
    logic [1:0] o_stim;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_fail;
    logic [2:0] o_err;

    always_comb begin
        o_stim = sel ? bus_b.stim      : bus_a.stim;
        o_busy = sel ? bus_b.busy      : bus_a.busy;
        o_done = sel ? bus_b.done      : bus_a.done;
        o_pass = sel ? bus_b.pass      : bus_a.pass;
        o_fail = sel ? bus_b.fail_vec  : bus_a.fail_vec;
        o_err  = sel ? bus_b.err_count : bus_a.err_count;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) bus_b.start = v; else bus_a.start = v;
    endtask

    task automatic set_abort(input logic v);
        if (sel) bus_b.abort = v; else bus_a.abort = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "/stim"}, 32'(o_stim), 0);
        check({tag, "/busy"}, 32'(o_busy), 0);
        check({tag, "/done"}, 32'(o_done), 0);
        check({tag, "/pass"}, 32'(o_pass), 0);
        check({tag, "/fail"}, 32'(o_fail), 0);
        check({tag, "/err"},  32'(o_err),  0);
    endtask

    // Launch a sweep on the selected instance and follow it edge by edge to completion.
    task automatic run_sweep(input string tag, input logic [3:0] tab, input int restart_at);
        int         s;
        int         len;
        logic [3:0] e;
        logic [3:0] ef;
        s   = sel ? SET_B : SET_A;
        e   = sel ? EXP_B : EXP_A;
        len = NV * (s + 1);
        for (int k = 0; k < NV; k++) ef[k] = (tab[k] != e[k]);
        if (sel) tab_b = tab; else tab_a = tab;

        @(negedge clk);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        check({tag, "/e0_busy"}, 32'(o_busy), 1);
        check({tag, "/e0_done"}, 32'(o_done), 0);
        check({tag, "/e0_fail"}, 32'(o_fail), 0);
        check({tag, "/e0_err"},  32'(o_err),  0);
        check({tag, "/e0_stim"}, 32'(o_stim), 0);

        for (int t = 1; t <= len; t++) begin
            if (t == restart_at) set_start(1'b1);
            tick();
            set_start(1'b0);
            if (t < len) begin
                check({tag, "/stim"}, 32'(o_stim), 32'(t / (s + 1)));
                check({tag, "/busy"}, 32'(o_busy), 1);
                check({tag, "/done"}, 32'(o_done), 0);
            end else begin
                check({tag, "/done"}, 32'(o_done), 1);
                check({tag, "/busy_end"}, 32'(o_busy), 0);
                check({tag, "/stim_end"}, 32'(o_stim), 0);
                check({tag, "/pass"}, 32'(o_pass), 32'(ef == 4'b0000));
                check({tag, "/fail_vec"}, 32'(o_fail), 32'(ef));
                check({tag, "/err_count"}, 32'(o_err), 32'($countones(ef)));
            end
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_a.abort = 1'b0;
        bus_b.start = 1'b0;
        bus_b.abort = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("and_ok", 4'b1000, 0);
        repeat (3) tick();
        check("hold/done", 32'(o_done), 1);
        check("hold/pass", 32'(o_pass), 1);
        check("hold/stim", 32'(o_stim), 0);

        run_sweep("stuck0", 4'b0000, 0);
        run_sweep("or_gate", 4'b1110, 0);
        run_sweep("restart_ignored", 4'b1000, 5);
        run_sweep("relaunch", 4'b0101, 0);

        // Asynchronous reset in the middle of vector 2, with failures already recorded.
        tab_a = 4'b0001;
        @(negedge clk);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (7) tick();
        check("mid/stim", 32'(o_stim), 2);
        check("mid/fail", 32'(o_fail), 32'(4'b0001));
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("post_rst", 4'b1000, 0);

        // Abort at edge 7 with start also high: abort wins, nothing relaunches.
        tab_a = 4'b0110;
        @(negedge clk);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (6) tick();
        set_abort(1'b1);
        set_start(1'b1);
        tick();
        set_abort(1'b0);
        set_start(1'b0);
        check_cleared("abort");
        repeat (3) tick();
        check_cleared("abort_idle");

        sel = 1'b1;
        run_sweep("s0_or", 4'b1110, 0);
        run_sweep("s0_and", 4'b1000, 0);

        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            run_sweep("rand", 4'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
